// File: rtl/ai_pkg.sv
// Shared state encoding, line masks and preferred-tile order for the move generator.
// Bit 8 is tile 0 and bit 0 is tile 8 in every board vector.
package ai_pkg;

   localparam int TILE_W = 9;

`ifdef AI_MOVE_HARD_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WIN   = 3'd1,
      BLOCK = 3'd2,
      PREF  = 3'd3,
      SCAN  = 3'd4,
      DONE  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd4,
      DONE  = 3'd5
   } state_t;
`endif

   // Index n holds line Ln: three rows, three columns, then the two diagonals.
   localparam logic [7:0][TILE_W-1:0] LINE_MASK = {
      9'b001_010_100,
      9'b100_010_001,
      9'b001_001_001,
      9'b010_010_010,
      9'b100_100_100,
      9'b000_000_111,
      9'b000_111_000,
      9'b111_000_000
   };

   // Highest-priority tile sits in the top nibble.
   localparam logic [35:0] PREF_ORDER = {4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};

   function automatic logic [TILE_W-1:0] tile_bit(input logic [3:0] t);
      logic [TILE_W-1:0] b;
      b = 9'b1_0000_0000 >> t;
      return b;
   endfunction

   function automatic logic [TILE_W-1:0] pref_pick(input logic [TILE_W-1:0] occ);
      logic [TILE_W-1:0] cand;
      logic [TILE_W-1:0] pick;
      pick = '0;
      // Walk lowest priority first so the highest-priority free tile is the last write.
      for (int i = 0; i < TILE_W; i++) begin
         cand = tile_bit(PREF_ORDER[i*4 +: 4]);
         if ((occ & cand) == '0) pick = cand;
      end
      return pick;
   endfunction

endpackage

// File: rtl/ai_line_eval.sv
// Combinational line test: returns the single empty tile of a line holding exactly two own marks.
// Returns zero when the line does not qualify.
module ai_line_eval
   import ai_pkg::*;
(
   input  logic [TILE_W-1:0] line_mask,
   input  logic [TILE_W-1:0] own,
   input  logic [TILE_W-1:0] occ,
   output logic [TILE_W-1:0] hit
);

   logic [TILE_W-1:0] own_in;
   logic [TILE_W-1:0] empty_in;
   logic [3:0]        own_cnt;

   always_comb begin
      own_in   = line_mask & own;
      empty_in = line_mask & ~occ;
      own_cnt  = '0;
      for (int i = 0; i < TILE_W; i++) begin
         own_cnt = own_cnt + {3'b000, own_in[i]};
      end
      // Two own marks on a three-tile line leave at most one tile that can be empty.
      hit = (own_cnt == 4'd2) ? empty_in : '0;
   end

endmodule

// File: rtl/ai_move_gen.sv
// Tic-tac-toe X move generator. Define AI_MOVE_HARD_EN for the win/block/prefer search;
// without it a first-empty-tile scan is built. valid pulses for one cycle in DONE.
module ai_move_gen
   import ai_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [TILE_W-1:0] x_state,
   input  logic [TILE_W-1:0] o_state,
   output logic [TILE_W-1:0] ai_move,
   output logic              valid,
   output logic              busy,
   output logic              full
);

   state_t            state_q, state_d;
   logic [TILE_W-1:0] x_q, x_d;
   logic [TILE_W-1:0] o_q, o_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [TILE_W-1:0] move_q, move_d;
   logic              full_q, full_d;
   logic [TILE_W-1:0] occ;

   assign occ = x_q | o_q;

`ifdef AI_MOVE_HARD_EN
   logic [TILE_W-1:0] line_hit;
   logic [TILE_W-1:0] own_sel;
   logic [TILE_W-1:0] pref_sel;

   assign own_sel  = (state_q == BLOCK) ? o_q : x_q;
   assign pref_sel = pref_pick(occ);

   ai_line_eval u_line_eval (
      .line_mask (LINE_MASK[cnt_q[2:0]]),
      .own       (own_sel),
      .occ       (occ),
      .hit       (line_hit)
   );
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      o_d     = o_q;
      cnt_d   = cnt_q;
      move_d  = move_q;
      full_d  = full_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               x_d    = x_state;
               o_d    = o_state;
               cnt_d  = '0;
               move_d = '0;
               full_d = 1'b0;
`ifdef AI_MOVE_HARD_EN
               state_d = WIN;
`else
               state_d = SCAN;
`endif
            end
         end
`ifdef AI_MOVE_HARD_EN
         WIN, BLOCK: begin
            if (line_hit != '0) begin
               move_d  = line_hit;
               state_d = DONE;
            end else if (cnt_q == 4'd7) begin
               cnt_d   = '0;
               state_d = (state_q == WIN) ? BLOCK : PREF;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         PREF: begin
            move_d  = pref_sel;
            full_d  = (pref_sel == '0);
            state_d = DONE;
         end
`endif
         SCAN: begin
            if ((occ & tile_bit(cnt_q)) == '0) begin
               move_d  = tile_bit(cnt_q);
               state_d = DONE;
            end else if (cnt_q == 4'd8) begin
               full_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         o_q     <= '0;
         cnt_q   <= '0;
         move_q  <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         o_q     <= o_d;
         cnt_q   <= cnt_d;
         move_q  <= move_d;
         full_q  <= full_d;
      end
   end

   assign ai_move = move_q;
   assign full    = full_q;
   assign valid   = (state_q == DONE);
   assign busy    = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_ai_move_gen.sv
// Scoreboard bench for ai_move_gen: expectations queued at request, checked on each valid pulse.
// Works for both builds; the case table follows AI_MOVE_HARD_EN.
module tb_ai_move_gen;

   logic       clk;
   logic       rst;
   logic       req;
   logic [8:0] x_state;
   logic [8:0] o_state;
   logic [8:0] ai_move;
   logic       valid;
   logic       busy;
   logic       full;

   typedef struct {
      logic [8:0] move;
      logic       full;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc;
   int   n_cmp;
   int   n_err;

   ai_move_gen dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .x_state (x_state),
      .o_state (o_state),
      .ai_move (ai_move),
      .valid   (valid),
      .busy    (busy),
      .full    (full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Monitor: every valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("ai_move", {23'd0, ai_move}, {23'd0, mon_e.move});
            chk("full", {31'd0, full}, {31'd0, mon_e.full});
            chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
            chk("busy_at_valid", {31'd0, busy}, 32'd0);
         end
      end
   end

   // Entered and left at a negedge; req is taken on the very next rising edge.
   task automatic run_case(input logic [8:0] x, input logic [8:0] o, input logic [8:0] em,
                           input logic ef, input int lat, input bit poke_busy);
      x_state = x;
      o_state = o;
      req     = 1'b1;
      sb.push_back('{move: em, full: ef, lat: lat, acc: cyc + 1});
      @(negedge clk);
      req = 1'b0;
      chk("busy_after_req", {31'd0, busy}, 32'd1);
      if (poke_busy) begin
         @(negedge clk);
         x_state = 9'b000_000_000;
         o_state = 9'b000_000_000;
         req     = 1'b1;
         @(negedge clk);
         req = 1'b0;
      end
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", sb.size(), 32'd0);
      sb.delete();
      repeat (poke_busy ? 25 : 3) @(negedge clk);
      chk("hold_move", {23'd0, ai_move}, {23'd0, em});
      chk("hold_full", {31'd0, full}, {31'd0, ef});
   endtask

   task automatic reset_mid(input logic [8:0] x, input logic [8:0] o);
      x_state = x;
      o_state = o;
      req     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ai_move", {23'd0, ai_move}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (25) @(negedge clk);
      chk("idle_after_rst", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      req     = 1'b0;
      x_state = '0;
      o_state = '0;
      #1;
      chk("init_ai_move", {23'd0, ai_move}, 32'd0);
      chk("init_valid", {31'd0, valid}, 32'd0);
      chk("init_busy", {31'd0, busy}, 32'd0);
      chk("init_full", {31'd0, full}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
`ifdef AI_MOVE_HARD_EN
      run_case(9'b110_000_000, 9'b000_110_000, 9'b001_000_000, 1'b0, 2,  1'b0);
      run_case(9'b100_000_000, 9'b000_110_000, 9'b000_001_000, 1'b0, 11, 1'b0);
      run_case(9'b000_000_000, 9'b000_000_000, 9'b000_010_000, 1'b0, 18, 1'b0);
      run_case(9'b000_010_000, 9'b000_000_000, 9'b100_000_000, 1'b0, 18, 1'b0);
      run_case(9'b001_010_000, 9'b000_000_000, 9'b000_000_100, 1'b0, 9,  1'b0);
      run_case(9'b110_000_000, 9'b000_000_011, 9'b001_000_000, 1'b0, 2,  1'b0);
      run_case(9'b101_011_010, 9'b010_100_101, 9'b000_000_000, 1'b1, 18, 1'b1);
      run_case(9'b100_000_000, 9'b000_110_000, 9'b000_001_000, 1'b0, 11, 1'b0);
      reset_mid(9'b000_000_000, 9'b000_000_000);
      run_case(9'b000_000_000, 9'b000_000_000, 9'b000_010_000, 1'b0, 18, 1'b0);
`else
      run_case(9'b000_000_000, 9'b000_000_000, 9'b100_000_000, 1'b0, 2,  1'b0);
      run_case(9'b110_000_000, 9'b000_000_000, 9'b001_000_000, 1'b0, 4,  1'b0);
      run_case(9'b111_111_110, 9'b000_000_000, 9'b000_000_001, 1'b0, 10, 1'b0);
      run_case(9'b100_000_000, 9'b100_000_000, 9'b010_000_000, 1'b0, 3,  1'b0);
      run_case(9'b101_011_010, 9'b010_100_101, 9'b000_000_000, 1'b1, 10, 1'b1);
      run_case(9'b110_000_000, 9'b000_000_000, 9'b001_000_000, 1'b0, 4,  1'b0);
      reset_mid(9'b111_111_000, 9'b000_000_000);
      run_case(9'b111_000_000, 9'b000_100_000, 9'b000_010_000, 1'b0, 6,  1'b0);
`endif
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/ai_move_gen.md
AI_MOVE_GEN -- requirements
Module: ai_move_gen

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-003 SHALL have ports: req  in  1  single-cycle request to compute the X (AI) move.
REQ-004 SHALL have ports: x_state  in  9  X occupancy; tile 0 = bit 8 ... tile 8 = bit 0.
REQ-005 SHALL have ports: o_state  in  9  O occupancy; same mapping as x_state.
REQ-006 SHALL have ports: ai_move  out  9  one-hot chosen tile, same bit mapping; 0 means no move.
REQ-007 SHALL have ports: valid  out  1  one-cycle pulse when ai_move is updated.
REQ-008 SHALL have ports: busy  out  1  high while a computation is in progress.
REQ-009 SHALL have ports: full  out  1  set with valid when no empty tile exists.

Function
REQ-010 SHALL implement states IDLE, WIN, BLOCK, PREF, SCAN, DONE.
REQ-011 SHALL accept req only in IDLE; at that edge latch x_state/o_state, clear ai_move/full, set busy; req in any other state ignored.
REQ-012 SHALL treat a tile as occupied if its bit is set in either latched board; overlapping bits are not an error.
REQ-013 SHALL use line order L0..L7: rows (0,1,2),(3,4,5),(6,7,8), cols (0,3,6),(1,4,7),(2,5,8), diags (0,4,8),(2,4,6).
REQ-014 WIN SHALL test one line per cycle, L0 first; a line with exactly two X tiles and one empty tile selects that empty tile -> DONE.
REQ-015 After L7 with no WIN match SHALL enter BLOCK and repeat the same test with O tiles instead of X.
REQ-016 After BLOCK L7 with no match SHALL enter PREF for one cycle, choosing the first empty tile in priority 4, 0, 2, 6, 8, 1, 3, 5, 7.
REQ-017 SCAN SHALL test one tile per cycle, from tile 0 upward; the first empty tile -> DONE.
REQ-018 DONE SHALL last one cycle with valid=1, busy=0, then return to IDLE.
REQ-019 Latency, hard path (req accepted at edge k): WIN line n is tested in cycle k+1+n; BLOCK line n in cycle k+9+n; PREF in cycle k+17; valid is asserted in the cycle after the cycle that selected the tile.
REQ-020 Latency, easy path: tile t is tested in cycle k+1+t; valid is asserted in cycle k+2+t.
REQ-021 If no empty tile is found (end of PREF or of SCAN tile 8), SHALL go to DONE with ai_move=0 and full=1.
REQ-022 ai_move and full SHALL hold their value from DONE until the next accepted req.

Reset
REQ-023 While rst=0, SHALL be in IDLE with ai_move=0, valid=0, busy=0, full=0, latched boards=0 and counters=0; this applies even mid-computation, and no valid pulse follows.
REQ-024 The first req SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro AI_MOVE_HARD_EN: when defined, req enters WIN and the WIN/BLOCK/PREF path is used; when undefined, req enters SCAN, and the WIN, BLOCK and PREF states and line logic are not compiled in.

Structure
REQ-026 Package ai_pkg SHALL hold: the state enum, the TILE_W=9 constant, the eight line masks L0..L7, and the PREF priority table.
REQ-027 One sub-module, ai_line_eval (combinational), SHALL take a line mask, an own-board and an occupied-board, and return the one-hot empty tile or 0.

Verification
REQ-028 Easy mode, empty board, req at edge k -> valid at cycle k+2, ai_move=9'b100_000_000, full=0.
REQ-029 Hard mode, x=9'b110_000_000, o=9'b000_110_000 -> WIN on L0, valid at cycle k+2, ai_move=9'b001_000_000.
REQ-030 Hard mode, x=9'b100_000_000, o=9'b000_110_000 -> BLOCK on L1, valid at cycle k+11, ai_move=9'b000_001_000.
REQ-031 Hard mode, x=0, o=0 -> PREF, valid at cycle k+18, ai_move=9'b000_010_000.
REQ-032 Either mode, x=9'b101_011_010, o=9'b010_100_101 -> valid with ai_move=0 and full=1; a req while busy=1 is ignored.
REQ-033 Hard mode, rst pulled low at cycle k+5 -> all outputs 0 immediately; no valid pulse; a req after release computes normally.
